// File: rtl/alu_reg_file_pkg.sv
// alu_reg_file_pkg: opcode constants and default widths for alu_reg_file
package alu_reg_file_pkg;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_REG_COUNT = 8;
  localparam int DEF_ADDR_W    = 3;
  localparam logic [2:0] OP_FWD = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SRA = 3'd6;
  localparam logic [2:0] OP_ROR = 3'd7;
endpackage

// File: rtl/alu_reg_file_alu_core.sv
// alu_core: combinational ALU; multiplier only built when ALU_MULT_EN is defined
module alu_core
  import alu_reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] i_op1,
  input  logic [DATA_W-1:0] i_op2,
  input  logic [2:0]        i_sel,
  input  logic              i_dir,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero
);
  localparam logic [DATA_W-1:0] W_L = DATA_W[DATA_W-1:0];
  logic [DATA_W-1:0] w_mul, w_shl, w_sra, w_amt, w_ror;
`ifdef ALU_MULT_EN
  assign w_mul = i_op1 * i_op2;
`else
  assign w_mul = '0;
`endif
  // full-value shift amounts: anything >= DATA_W drains to zero / sign copies
  assign w_shl = i_dir ? i_op1 >> i_op2 : i_op1 << i_op2;
  assign w_sra = $signed(i_op1) >>> i_op2;
  assign w_amt = i_op2 % W_L;
  assign w_ror = (i_op1 >> w_amt) | (i_op1 << (W_L - w_amt));
  assign o_result = (i_sel == OP_FWD) ? i_op2 :
                    (i_sel == OP_ADD) ? i_op1 + i_op2 :
                    (i_sel == OP_AND) ? i_op1 & i_op2 :
                    (i_sel == OP_OR)  ? i_op1 | i_op2 :
                    (i_sel == OP_MUL) ? w_mul :
                    (i_sel == OP_SHL) ? w_shl :
                    (i_sel == OP_SRA) ? w_sra : w_ror;
  assign o_zero = o_result == '0;
endmodule

// File: rtl/alu_reg_file.sv
// alu_reg_file: register file with operand muxing feeding alu_core; build with ALU_MULT_EN to enable multiply
module alu_reg_file
  import alu_reg_file_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int REG_COUNT = DEF_REG_COUNT,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WRITEENABLE,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  input  logic [DATA_W-1:0] IMMEDIATE,
  input  logic              IMM_SEL,
  input  logic              NEG_SEL,
  input  logic [2:0]        SELECT,
  input  logic              SHIFT_DIRECTION,
  output logic [DATA_W-1:0] REGOUT1,
  output logic [DATA_W-1:0] REGOUT2,
  output logic [DATA_W-1:0] RESULT,
  output logic              ZERO
);
  logic [DATA_W-1:0] r_regs [REG_COUNT];
  logic [DATA_W-1:0] w_op2;
  assign REGOUT1 = r_regs[OUT1ADDRESS];
  assign REGOUT2 = r_regs[OUT2ADDRESS];
  assign w_op2 = IMM_SEL ? IMMEDIATE : NEG_SEL ? -REGOUT2 : REGOUT2;
  alu_core #(.DATA_W(DATA_W)) u_alu (
    .i_op1    (REGOUT1),
    .i_op2    (w_op2),
    .i_sel    (SELECT),
    .i_dir    (SHIFT_DIRECTION),
    .o_result (RESULT),
    .o_zero   (ZERO)
  );
  always_ff @(posedge CLK) begin
    if (RESET) r_regs <= '{default: '0};
    else if (WRITEENABLE) r_regs[INADDRESS] <= RESULT;
  end
endmodule

// File: tb/tb_alu_reg_file.sv
// tb_alu_reg_file: directed scenarios plus randomized run against an integer reference model
module tb_alu_reg_file;
  logic       clk = 0, rst = 0, we = 0, imm_sel = 0, neg_sel = 0, dir = 0;
  logic [2:0] in_a = 0, o1_a = 0, o2_a = 0, sel = 0;
  logic [7:0] imm = 0;
  logic [7:0] rout1, rout2, res;
  logic       zero;
  int total = 0, bad = 0;
  int mdl [8];

  always #5 clk = ~clk;

  alu_reg_file dut (
    .CLK(clk), .RESET(rst), .WRITEENABLE(we), .INADDRESS(in_a),
    .OUT1ADDRESS(o1_a), .OUT2ADDRESS(o2_a), .IMMEDIATE(imm),
    .IMM_SEL(imm_sel), .NEG_SEL(neg_sel), .SELECT(sel),
    .SHIFT_DIRECTION(dir), .REGOUT1(rout1), .REGOUT2(rout2),
    .RESULT(res), .ZERO(zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_alu(input int a, input int b, input int op, input int d);
    int v, p, r;
    r = 0;
    case (op)
      0: r = b;
      1: r = a + b;
      2: r = a & b;
      3: r = a | b;
      4: begin
`ifdef ALU_MULT_EN
        r = a * b;
`else
        r = 0;
`endif
      end
      5: r = (b >= 8) ? 0 : (d != 0 ? a / (1 << b) : a * (1 << b));
      6: begin
        v = (a >= 128) ? a - 256 : a;
        if (b >= 8) r = (v < 0) ? -1 : 0;
        else begin
          p = 1 << b;
          r = (v >= 0) ? v / p : -((-v + p - 1) / p);
        end
      end
      default: begin
        v = b % 8;
        r = (a / (1 << v)) + (a * (1 << (8 - v)));
      end
    endcase
    return r & 255;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int v);
    imm_sel = 1; neg_sel = 0; imm = v[7:0]; sel = 3'd0; in_a = a[2:0]; we = 1;
    tick();
    we = 0;
  endtask

  initial begin
    // reset clears everything
    rst = 1; we = 0;
    tick();
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      o1_a = i[2:0]; o2_a = 3'(7 - i);
      #1;
      check("rst_r1", rout1, 0);
      check("rst_r2", rout2, 0);
    end
    wr(2, 8'h05);
    o1_a = 3'd2; #1;
    check("wr_imm", rout1, 8'h05);

    // subtract / compare
    wr(1, 5); wr(2, 5);
    o1_a = 3'd1; o2_a = 3'd2; imm_sel = 0; neg_sel = 1; sel = 3'd1; #1;
    check("sub_eq", res, 0);
    check("sub_eq_z", zero, 1);
    wr(2, 3);
    o1_a = 3'd1; o2_a = 3'd2; imm_sel = 0; neg_sel = 1; sel = 3'd1; #1;
    check("sub_ne", res, 2);
    check("sub_ne_z", zero, 0);

    // shifts
    wr(1, 8'h81);
    o1_a = 3'd1; imm_sel = 1; neg_sel = 0; imm = 8'd1;
    sel = 3'd5; dir = 0; #1; check("shl1", res, 8'h02);
    dir = 1; #1; check("shr1", res, 8'h40);
    sel = 3'd6; #1; check("sra1", res, 8'hC0);
    sel = 3'd7; #1; check("ror1", res, 8'hC0);
    imm = 8'd9;
    sel = 3'd5; dir = 0; #1; check("shl9", res, 8'h00);
    check("shl9_z", zero, 1);
    dir = 1; #1; check("shr9", res, 8'h00);
    sel = 3'd6; #1; check("sra9", res, 8'hFF);
    sel = 3'd7; #1; check("ror9", res, 8'hC0);

    // logic and multiply
    wr(1, 8'hF0); wr(2, 8'h3C);
    o1_a = 3'd1; o2_a = 3'd2; imm_sel = 0; neg_sel = 0;
    sel = 3'd2; #1; check("and", res, 8'h30);
    sel = 3'd3; #1; check("or", res, 8'hFC);
    wr(1, 20); wr(2, 13);
    o1_a = 3'd1; o2_a = 3'd2; imm_sel = 0; neg_sel = 0; sel = 3'd4; #1;
`ifdef ALU_MULT_EN
    check("mul", res, 8'h04);
    check("mul_z", zero, 0);
`else
    check("mul", res, 8'h00);
    check("mul_z", zero, 1);
`endif

    // reset beats a simultaneous write
    wr(3, 8'h77);
    imm_sel = 1; imm = 8'h55; sel = 3'd0; in_a = 3'd3; we = 1; rst = 1;
    tick();
    rst = 0; we = 0; o1_a = 3'd3; #1;
    check("rst_vs_wr", rout1, 0);

    // no writes while disabled, even with RESULT moving
    for (int i = 0; i < 8; i++) wr(i, 8'h10 + i);
    for (int k = 0; k < 4; k++) begin
      imm_sel = 1; imm = 8'(k * 37 + 1); sel = 3'd0; in_a = k[2:0]; we = 0;
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      o1_a = i[2:0]; #1;
      check("we0_hold", rout1, 8'h10 + i);
    end

    // read during write
    wr(4, 8'h11);
    imm_sel = 1; imm = 8'h22; sel = 3'd0; in_a = 3'd4; o1_a = 3'd4; we = 1; #1;
    check("rdw_old", rout1, 8'h11);
    tick();
    we = 0; #1;
    check("rdw_new", rout1, 8'h22);

    // randomized run against the model
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 8; i++) mdl[i] = 0;
    for (int n = 0; n < 400; n++) begin
      int a, b, e;
      rst = ($urandom_range(0, 29) == 0);
      we = $urandom_range(0, 1);
      in_a = 3'($urandom); o1_a = 3'($urandom); o2_a = 3'($urandom);
      imm_sel = $urandom_range(0, 1); neg_sel = $urandom_range(0, 1);
      sel = 3'($urandom); dir = $urandom_range(0, 1);
      imm = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      #1;
      a = mdl[o1_a];
      b = imm_sel ? int'(imm) : neg_sel ? (256 - mdl[o2_a]) % 256 : mdl[o2_a];
      e = ref_alu(a, b, int'(sel), int'(dir));
      check("rnd_r1", rout1, a);
      check("rnd_r2", rout2, mdl[o2_a]);
      check("rnd_res", res, e);
      check("rnd_zero", zero, e == 0);
      tick();
      if (rst) for (int i = 0; i < 8; i++) mdl[i] = 0;
      else if (we) mdl[in_a] = e;
    end
    rst = 0; we = 0;
    for (int i = 0; i < 8; i++) begin
      o1_a = i[2:0]; #1;
      check("rnd_final", rout1, mdl[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
